// File: rtl/trace_pkg.sv
// Shared encodings and entry-width helper for the write-back trace buffer.
// Defining TRACE_TIMESTAMP_EN widens each entry by a 32-bit cycle stamp.
package trace_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_WRAP = 2'd1,
    MODE_TRIG = 2'd2,
    MODE_RSVD = 2'd3
  } trace_mode_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } trace_state_t;

  localparam int TS_W = 32;

  function automatic int entry_width(input int addr_w, input int reg_w, input int data_w);
`ifdef TRACE_TIMESTAMP_EN
    return addr_w + reg_w + data_w + TS_W;
`else
    return addr_w + reg_w + data_w;
`endif
  endfunction

  localparam int ENTRY_W = entry_width(32, 5, 32);

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one combinational read port.
module trace_ram #(
  parameter int W     = 69,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures retiring register writes into a circular buffer with STOP/WRAP/TRIG policies.
// Optional TRACE_TIMESTAMP_EN adds a per-entry cycle stamp and the rd_ts output.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5,
  parameter int DEPTH    = 16,
  parameter int POST_CNT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [ADDR_W-1:0]        trig_pc,
  input  logic                     clear,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_pc,
  input  logic [REG_W-1:0]         wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [REG_W-1:0]         rd_reg,
  output logic [DATA_W-1:0]        rd_data,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]          rd_ts,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     triggered,
  output logic                     frozen
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = entry_width(ADDR_W, REG_W, DATA_W);

  logic [PTR_W-1:0] wptr_reg, rptr_reg, post_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg, triggered_reg;
  trace_state_t     state_reg;
  trace_mode_t      eff_mode;
  logic             pop, cap_req, full, stop_mode, wr_en, overwrite, drop, trig_hit;
  logic [EW-1:0]    wdata, rdata;

  // Only TRIG mode can leave RUN, so POST keeps TRIG semantics until a clear.
  assign eff_mode  = (state_reg == ST_RUN) ? trace_mode_t'(mode) : MODE_TRIG;
  assign rd_valid  = (count_reg != '0);
  assign pop       = rd_valid & rd_ready;
  assign cap_req   = enable & wb_valid & (wb_rd != '0) & (state_reg != ST_FROZEN);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign stop_mode = (eff_mode == MODE_STOP) || (eff_mode == MODE_RSVD);
  assign wr_en     = cap_req & (~full | pop | ~stop_mode);
  assign overwrite = cap_req & full & ~pop & ~stop_mode;
  assign drop      = cap_req & full & ~pop & stop_mode;
  assign trig_hit  = wr_en & (state_reg == ST_RUN) & (eff_mode == MODE_TRIG) & (wb_pc == trig_pc);

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_reg <= '0;
    else        ts_reg <= ts_reg + 1'b1;
  end

  assign wdata = {wb_pc, wb_rd, wb_data, ts_reg};
  assign {rd_pc, rd_reg, rd_data, rd_ts} = rd_valid ? rdata : '0;
`else
  assign wdata = {wb_pc, wb_rd, wb_data};
  assign {rd_pc, rd_reg, rd_data} = rd_valid ? rdata : '0;
`endif

  trace_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en & ~clear),
    .waddr (wptr_reg),
    .wdata (wdata),
    .raddr (rptr_reg),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      post_reg      <= '0;
      overflow_reg  <= 1'b0;
      triggered_reg <= 1'b0;
      state_reg     <= ST_RUN;
    end else if (clear) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      post_reg      <= '0;
      overflow_reg  <= 1'b0;
      triggered_reg <= 1'b0;
      state_reg     <= ST_RUN;
    end else begin
      if (wr_en) wptr_reg <= wptr_reg + 1'b1;
      if (pop || overwrite) rptr_reg <= rptr_reg + 1'b1;
      if (wr_en && !pop && !full)   count_reg <= count_reg + 1'b1;
      else if (pop && !wr_en)       count_reg <= count_reg - 1'b1;
      if (overwrite || drop) overflow_reg <= 1'b1;
      case (state_reg)
        ST_RUN: begin
          if (trig_hit) begin
            triggered_reg <= 1'b1;
            post_reg      <= PTR_W'(POST_CNT);
            state_reg     <= (POST_CNT == 0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          if (wr_en) begin
            post_reg <= post_reg - 1'b1;
            if (post_reg == PTR_W'(1)) state_reg <= ST_FROZEN;
          end
        end
        default: state_reg <= ST_FROZEN;
      endcase
    end
  end

  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign triggered = triggered_reg;
  assign frozen    = (state_reg == ST_FROZEN);

endmodule
